// File: rtl/mux_arbiter_pkg.sv
// Shared encodings for the two-requester mux arbiter.
// The grant helper serves both the idle pick and the release hand-off.
package mux_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    // Prefer whichever requester did not own the mux last; a lone requester always wins.
    function automatic state_t grant(input logic req_a, input logic req_b, input logic last_a);
        state_t g;
        g = IDLE;
        if (req_a && (!req_b || !last_a))
            g = OWN_A;
        else if (req_b)
            g = OWN_B;
        return g;
    endfunction

endpackage

// File: rtl/mux_arbiter_mux.sv
// Plain 2:1 data mux: sel=1 passes a, sel=0 passes b.
module mux #(
    parameter int WIDTH = 32
) (
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel
);

    assign y = sel ? a : b;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner of the shared mux select, with a per-owner burst cap.
// Handshake: a beat moves when out_valid && out_ready; the owner's ack fires in that same cycle.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             out_ready,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic             ack_a,
    output logic             ack_b,
    output logic [1:0]       owner
);

    localparam int CW = $clog2(MAX_BURST + 1);

    state_t          state;
    logic            last_a;
    logic [CW-1:0]   beat_cnt;
    logic            own_req;
    logic            transfer;
    logic            at_cap;
    logic            release_now;
    state_t          next_grant;

    assign own_req     = (state == OWN_A) ? req_a : (state == OWN_B) ? req_b : 1'b0;
    // Gated by rst so a burst cut off by reset never acks in the reset cycle.
    assign out_valid   = own_req && !rst;
    assign transfer    = out_valid && out_ready;
    assign ack_a       = transfer && (state == OWN_A);
    assign ack_b       = transfer && (state == OWN_B);
    assign at_cap      = (beat_cnt == CW'(MAX_BURST - 1));
    assign release_now = !own_req || (transfer && at_cap);
    assign next_grant  = grant(req_a, req_b, (state == IDLE) ? last_a : (state == OWN_A));
    assign owner       = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= SEL_A;
            beat_cnt <= '0;
            last_a   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (next_grant != IDLE) begin
                        state <= next_grant;
                        sel   <= (next_grant == OWN_A) ? SEL_A : SEL_B;
                    end
                end
                OWN_A, OWN_B: begin
                    if (release_now) begin
                        last_a   <= (state == OWN_A);
                        beat_cnt <= '0;
                        state    <= next_grant;
                        if (next_grant != IDLE)
                            sel <= (next_grant == OWN_A) ? SEL_A : SEL_B;
                    end else if (transfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mux #(.WIDTH(WIDTH)) u_mux (
        .y   (y),
        .a   (a),
        .b   (b),
        .sel (sel)
    );

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Round-robin controller that shares the 32-bit 2:1 mux (sel=1 passes a, sel=0 passes b) between two requesters, A and B, driving one downstream consumer.
- Owns and sequences the mux select line.
- Grants one requester at a time and caps ownership at a burst limit so neither requester starves.
- Beats are handed to the consumer with a valid/ready handshake, and each accepted beat is acknowledged back to its requester.

Parameters:
- WIDTH, 32, data width of a, b and y.
- MAX_BURST, 4, maximum beats accepted from one owner before ownership is re-arbitrated; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_a  in  1  requester A has a beat on a; held until ack_a.
- req_b  in  1  requester B has a beat on b; held until ack_b.
- a  in  WIDTH  requester A data.
- b  in  WIDTH  requester B data.
- out_ready  in  1  consumer can accept a beat this cycle.
- sel  out  1  registered mux select; 1 passes a, 0 passes b.
- y  out  WIDTH  mux output, combinational from a, b and sel.
- out_valid  out  1  y carries a valid beat.
- ack_a  out  1  A's beat was accepted this cycle.
- ack_b  out  1  B's beat was accepted this cycle.
- owner  out  2  current state: 00 IDLE, 01 OWN_A, 10 OWN_B.

Behaviour:
- Reset (rst=1 at an edge):
  - state IDLE, sel=1, beat_cnt=0, last_owner=B.
  - out_valid, ack_a and ack_b are 0 in the following cycle.
  - Reset mid-burst abandons the burst; no ack is issued in the reset cycle.
- States:
  - IDLE: out_valid=0, sel holds its last value.
  - OWN_A: sel=1, out_valid=req_a.
  - OWN_B: sel=0, out_valid=req_b.
- Transfer and acks:
  - A transfer occurs when out_valid && out_ready.
  - ack_x = transfer && owner==x, combinational in the same cycle.
  - The requester may change data or drop req_x after the ack edge.
- IDLE transitions:
  - Only one requester active: go to that requester's OWN state.
  - Both active: grant the one that is not last_owner.
  - One cycle of latency from first req to out_valid.
- Release in OWN_x occurs at the edge where either:
  - req_x=0 with no transfer pending, or
  - the transfer brings beat_cnt to MAX_BURST.
- On release:
  - Other requester active: switch directly to the other OWN state, with no idle bubble.
  - Otherwise, req_x still active (burst cap hit): re-grant x.
  - Otherwise: go to IDLE.
  - In all cases last_owner=x and beat_cnt is reset to 0.
- beat_cnt:
  - Width $clog2(MAX_BURST+1).
  - Increments on each transfer and never exceeds MAX_BURST.
- sel changes only on state entry, so y is stable for the whole ownership period.
- Handshake violation: if req_x drops without an ack, the beat is dropped silently; no error is flagged.
- out_ready low:
  - Ownership is held indefinitely and out_valid stays high.
  - This is a back-pressure stall, not a starvation case.

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'b00, OWN_A=2'b01, OWN_B=2'b10;
  - SEL_A=1'b1 and SEL_B=1'b0.
- Instantiate the existing 32-bit mux as the single sub-module (mux, ports y/a/b/sel), driven by the registered sel.
- FSM, burst counter and round-robin pointer live in mux_arbiter.

Test Plan:
- Reset, then idle:
  - Stimulus: rst=1 for 2 cycles, then req_a=req_b=0.
  - Required: sel=1, out_valid=0, owner=00.
- Single requester:
  - Stimulus: a=32'hAAAAAAAA, req_a=1, out_ready=1.
  - Required: next cycle owner=01, y=AAAAAAAA, out_valid=1, ack_a=1 each cycle.
- Contention, round-robin:
  - Stimulus: req_a=req_b=1, a=32'hA5A5A5A5, b=32'h55555555, out_ready=1, MAX_BURST=4.
  - Required: 4 acks on A, then sel=0 with no bubble, 4 acks on B, then back to A.
- Back-pressure:
  - Stimulus: in OWN_B with b=32'hDDDDDDDD, out_ready=0 for 5 cycles.
  - Required: out_valid=1, y=DDDDDDDD held, beat_cnt unchanged, no ack.
- Reset mid-burst:
  - Stimulus: rst=1 after 2 A beats, both requests still active.
  - Required: IDLE, sel=1; on release A is granted first (last_owner=B).
- Early release:
  - Stimulus: req_b drops after 1 beat while req_a=1.
  - Required: owner goes 10 to 01 in one cycle, y=a.
